// File: rtl/sraml_responder.sv
// sraml_responder: SRAM-like slave port in front of a single-port word RAM.
// One transaction in flight: accept, optional wait cycles, one RAM access,
// then a one-cycle data_ok response.
//
// Parameters:
//   ADDR_W   word-address width of the RAM port
//   LATENCY  extra wait cycles before each RAM access (0..15)
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req, wr, size, addr      request valid, direction, size, byte address
//   wdata                    lane-placed write data
//   addr_ok                  request accepted when req & addr_ok
//   data_ok, rdata           completion pulse and read data
//   ram_en, ram_wen          RAM strobe and byte write enables
//   ram_addr, ram_wdata      RAM word address and write data
//   ram_rdata                RAM read data, one cycle after a read strobe
module sraml_responder #(
    parameter int ADDR_W  = 16,
    parameter int LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [1:0]        size,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              addr_ok,
    output logic              data_ok,
    output logic [31:0]       rdata,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    // Latched request fields; only the bits the RAM can see are kept.
    logic              l_wr;
    logic [1:0]        l_size;
    logic [1:0]        l_lo;
    logic [ADDR_W-1:0] l_word;
    logic [31:0]       l_wdata;

    logic       accept;
    logic [3:0] lane_mask;

    // Address bits above the RAM are dropped, so addresses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:ADDR_W+2];

    // Decoded from the state register only; reset holds it low.
    assign addr_ok = (state == IDLE) && !rst;
    assign accept  = req && addr_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            l_wr    <= 1'b0;
            l_size  <= 2'd0;
            l_lo    <= 2'd0;
            l_word  <= '0;
            l_wdata <= 32'd0;
        end else if (accept) begin
            l_wr    <= wr;
            l_size  <= size;
            l_lo    <= addr[1:0];
            l_word  <= addr[ADDR_W+1:2];
            l_wdata <= wdata;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    cnt_nxt   = 4'(LATENCY);
                    state_nxt = (LATENCY > 0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                // Saturating down-count; leave on the last wait cycle.
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end
                if (cnt <= 4'd1) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: state_nxt = RESP;
            RESP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Misaligned accesses are aligned down to their natural lanes.
    always_comb begin
        lane_mask = 4'b1111;
        unique case (l_size)
            2'd0:    lane_mask = 4'b0001 << l_lo;
            2'd1:    lane_mask = 4'b0011 << {l_lo[1], 1'b0};
            default: lane_mask = 4'b1111;
        endcase
    end

    // Reset also gates the outputs so a dropped transaction never
    // reaches the RAM or the initiator.
    assign ram_en    = (state == ACCESS) && !rst;
    assign ram_wen   = (ram_en && l_wr) ? lane_mask : 4'd0;
    assign ram_addr  = ram_en ? l_word : '0;
    assign ram_wdata = ram_en ? l_wdata : 32'd0;

    assign data_ok = (state == RESP) && !rst;
    assign rdata   = (data_ok && !l_wr) ? ram_rdata : 32'd0;

endmodule

// File: tb/tb_sraml_responder.sv
// Bench for sraml_responder: three configurations checked every cycle
// against a transaction-phase model, plus directed literal scenarios.
module tb_sraml_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0]       rst_p   = 3'b111;
    logic [2:0]       req_p   = 3'b000;
    logic [2:0]       wr_p    = 3'b000;
    logic [2:0][1:0]  size_p  = '0;
    logic [2:0][31:0] addr_p  = '0;
    logic [2:0][31:0] wdata_p = '0;

    logic [2:0]       ao_p;
    logic [2:0]       dok_p;
    logic [2:0]       en_p;
    logic [2:0][31:0] rd_p;
    logic [2:0][3:0]  wen_p;
    logic [2:0][15:0] ra_p;
    logic [2:0][31:0] wd_p;

    task automatic chk(input string nm, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d] got %h want %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Byte lanes touched by an access of the given size, aligned down.
    function automatic logic [3:0] lanes(input logic [1:0] s, input logic [31:0] a);
        int n;
        int first;
        logic [3:0] m;
        n = (s == 2'd0) ? 1 : ((s == 2'd1) ? 2 : 4);
        first = (int'(a[1:0]) / n) * n;
        m = 4'd0;
        for (int b = 0; b < 4; b++) m[b] = (b >= first) && (b < first + n);
        return m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0] en);
        logic [31:0] o;
        o = old;
        for (int b = 0; b < 4; b++) if (en[b]) o[b*8 +: 8] = d[b*8 +: 8];
        return o;
    endfunction

    function automatic int widx(input logic [31:0] a, input int aw);
        return int'((a >> 2) & ((32'd1 << aw) - 32'd1));
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int L     = (g == 0) ? 0 : ((g == 1) ? 3 : 5);
        localparam int AW    = (g == 0) ? 16 : ((g == 1) ? 4 : 8);
        localparam int DEPTH = 1 << AW;

        logic          lao, ldok, len;
        logic [31:0]   lrd, lwd;
        logic [31:0]   lrrd = 32'd0;
        logic [3:0]    lwen;
        logic [AW-1:0] lra;

        logic [31:0] ram [DEPTH];
        logic [31:0] mm  [DEPTH];

        // Model: k = cycles since acceptance (0 = idle).
        int          k    = 0;
        logic        m_wr = 1'b0;
        logic [1:0]  m_sz = 2'd0;
        logic [31:0] m_a  = 32'd0;
        logic [31:0] m_d  = 32'd0;

        sraml_responder #(.ADDR_W(AW), .LATENCY(L)) dut (
            .clk(clk), .rst(rst_p[g]), .req(req_p[g]), .wr(wr_p[g]),
            .size(size_p[g]), .addr(addr_p[g]), .wdata(wdata_p[g]),
            .addr_ok(lao), .data_ok(ldok), .rdata(lrd),
            .ram_en(len), .ram_wen(lwen), .ram_addr(lra),
            .ram_wdata(lwd), .ram_rdata(lrrd)
        );

        assign ao_p[g]  = lao;
        assign dok_p[g] = ldok;
        assign en_p[g]  = len;
        assign rd_p[g]  = lrd;
        assign wen_p[g] = lwen;
        assign ra_p[g]  = 16'(lra);
        assign wd_p[g]  = lwd;

        initial begin
            for (int j = 0; j < DEPTH; j++) begin
                ram[j] = 32'd0;
                mm[j]  = 32'd0;
            end
        end

        // Backing RAM seen by the DUT.
        always @(posedge clk) begin
            if (len) begin
                ram[lra] <= merge(ram[lra], lwd, lwen);
                if (lwen == 4'd0) lrrd <= ram[lra];
            end
        end

        always @(posedge clk) begin
            if (rst_p[g]) begin
                k <= 0;
            end else if (k == 0) begin
                if (req_p[g]) begin
                    k    <= 1;
                    m_wr <= wr_p[g];
                    m_sz <= size_p[g];
                    m_a  <= addr_p[g];
                    m_d  <= wdata_p[g];
                end
            end else begin
                if (k == L + 1 && m_wr)
                    mm[widx(m_a, AW)] <= merge(mm[widx(m_a, AW)], m_d, lanes(m_sz, m_a));
                k <= (k == L + 2) ? 0 : k + 1;
            end
        end

        always @(negedge clk) begin
            if (rst_p[g]) begin
                chk("rst_addr_ok", g, 32'(lao), 32'd0);
                chk("rst_data_ok", g, 32'(ldok), 32'd0);
                chk("rst_rdata", g, lrd, 32'd0);
                chk("rst_ram_en", g, 32'(len), 32'd0);
                chk("rst_ram_wen", g, 32'(lwen), 32'd0);
                chk("rst_ram_addr", g, 32'(lra), 32'd0);
                chk("rst_ram_wdata", g, lwd, 32'd0);
            end else begin
                chk("addr_ok", g, 32'(lao), 32'(k == 0));
                chk("ram_en", g, 32'(len), 32'(k == L + 1));
                chk("ram_wen", g, 32'(lwen),
                    32'((k == L + 1 && m_wr) ? lanes(m_sz, m_a) : 4'd0));
                if (k == L + 1) begin
                    chk("ram_addr", g, 32'(lra), 32'(widx(m_a, AW)));
                    chk("ram_wdata", g, lwd, m_d);
                end
                chk("data_ok", g, 32'(ldok), 32'(k == L + 2));
                chk("rdata", g, lrd,
                    (k == L + 2 && !m_wr) ? mm[widx(m_a, AW)] : 32'd0);
            end
        end
    end

    // Issue one request on instance i and observe it to completion.
    task automatic xact(input int i, input int lat, input logic w,
                        input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d,
                        output logic [3:0] wen_s, output logic [15:0] ra_s,
                        output logic [31:0] rd_s, output int dk,
                        output int ok_k);
        bit got;
        got = 1'b0;
        req_p[i] = 1'b1; wr_p[i] = w; size_p[i] = s;
        addr_p[i] = a; wdata_p[i] = d;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (ao_p[i]) got = 1'b1;
            @(posedge clk); #1;
        end
        req_p[i] = 1'b0;
        chk("accept", i, 32'(got), 32'd1);
        wen_s = 4'd0; ra_s = 16'd0; rd_s = 32'd0; dk = -1; ok_k = -1;
        for (int kk = 1; kk <= lat + 3; kk++) begin
            @(negedge clk);
            if (en_p[i]) begin
                wen_s = wen_p[i];
                ra_s  = ra_p[i];
            end
            if (dok_p[i] && dk < 0) begin
                dk   = kk;
                rd_s = rd_p[i];
            end
            if (ao_p[i] && ok_k < 0) ok_k = kk;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: run did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  wen_s;
        logic [15:0] ra_s;
        logic [31:0] rd_s;
        int dk, ok_k;
        int n_ao, n_dok, n_ov, n_en;

        repeat (3) @(posedge clk);
        #1 rst_p = 3'b000;
        @(negedge clk);
        chk("addr_ok_after_rst", 0, 32'(ao_p[0]), 32'd1);
        @(posedge clk); #1;

        // Word write then read back, no wait cycles.
        xact(0, 0, 1'b1, 2'd2, 32'h10, 32'hDEADBEEF, wen_s, ra_s, rd_s, dk, ok_k);
        chk("w_wen", 0, 32'(wen_s), 32'hF);
        chk("w_ram_addr", 0, 32'(ra_s), 32'd4);
        chk("w_data_ok_lat", 0, dk, 2);
        chk("w_addr_ok_back", 0, ok_k, 3);
        xact(0, 0, 1'b0, 2'd2, 32'h10, 32'h0, wen_s, ra_s, rd_s, dk, ok_k);
        chk("r_rdata", 0, rd_s, 32'hDEADBEEF);
        chk("r_data_ok_lat", 0, dk, 2);
        chk("r_wen", 0, 32'(wen_s), 32'h0);

        // Lane enables, including an aligned-down halfword.
        xact(0, 0, 1'b1, 2'd0, 32'h13, 32'hAB000000, wen_s, ra_s, rd_s, dk, ok_k);
        chk("b13_wen", 0, 32'(wen_s), 32'h8);
        xact(0, 0, 1'b1, 2'd1, 32'h12, 32'h12340000, wen_s, ra_s, rd_s, dk, ok_k);
        chk("h12_wen", 0, 32'(wen_s), 32'hC);
        xact(0, 0, 1'b1, 2'd1, 32'h13, 32'h56780000, wen_s, ra_s, rd_s, dk, ok_k);
        chk("h13_wen", 0, 32'(wen_s), 32'hC);

        // req held high: accept every 3 cycles, one data_ok each.
        n_ao = 0; n_dok = 0; n_ov = 0;
        req_p[0] = 1'b1; wr_p[0] = 1'b0; size_p[0] = 2'd2; addr_p[0] = 32'h10;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ao_p[0]) n_ao++;
            if (dok_p[0]) n_dok++;
            if (ao_p[0] && dok_p[0]) n_ov++;
            @(posedge clk); #1;
        end
        req_p[0] = 1'b0;
        chk("b2b_accepts", 0, n_ao, 4);
        chk("b2b_data_ok", 0, n_dok, 4);
        chk("b2b_overlap", 0, n_ov, 0);

        // Three wait cycles, 4-bit RAM address wrap.
        xact(1, 3, 1'b1, 2'd2, 32'h40, 32'h11223344, wen_s, ra_s, rd_s, dk, ok_k);
        chk("wrap40_ram_addr", 1, 32'(ra_s), 32'd0);
        chk("lat3_data_ok", 1, dk, 5);
        chk("lat3_addr_ok_back", 1, ok_k, 6);
        xact(1, 3, 1'b1, 2'd2, 32'h3C, 32'h55667788, wen_s, ra_s, rd_s, dk, ok_k);
        chk("w3c_ram_addr", 1, 32'(ra_s), 32'd15);
        xact(1, 3, 1'b0, 2'd2, 32'h3C, 32'h0, wen_s, ra_s, rd_s, dk, ok_k);
        chk("r3c_rdata", 1, rd_s, 32'h55667788);
        chk("r3c_data_ok", 1, dk, 5);
        xact(1, 3, 1'b0, 2'd2, 32'h0, 32'h0, wen_s, ra_s, rd_s, dk, ok_k);
        chk("r0_wrapped", 1, rd_s, 32'h11223344);

        // Reset while waiting drops the transaction.
        req_p[2] = 1'b1; wr_p[2] = 1'b0; size_p[2] = 2'd2; addr_p[2] = 32'h8;
        n_ao = 0;
        for (int t = 0; t < 20 && n_ao == 0; t++) begin
            @(negedge clk);
            if (ao_p[2]) n_ao = 1;
            @(posedge clk); #1;
        end
        req_p[2] = 1'b0;
        chk("rstw_accept", 2, n_ao, 1);
        @(posedge clk); #1;
        rst_p[2] = 1'b1;
        @(posedge clk); #1;
        rst_p[2] = 1'b0;
        @(negedge clk);
        chk("rstw_addr_ok", 2, 32'(ao_p[2]), 32'd1);
        n_en = 0; n_dok = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (en_p[2]) n_en++;
            if (dok_p[2]) n_dok++;
        end
        chk("rstw_ram_en", 2, n_en, 0);
        chk("rstw_data_ok", 2, n_dok, 0);
        @(posedge clk); #1;

        // Random traffic on all three instances.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                rst_p[i]   = ($urandom % 64) == 0;
                req_p[i]   = ($urandom % 3) != 0;
                wr_p[i]    = $urandom % 2;
                size_p[i]  = 2'($urandom % 4);
                if (($urandom % 8) == 0)
                    addr_p[i] = $urandom;
                else
                    addr_p[i] = ($urandom & 32'hFFFC_0000) | 32'($urandom_range(0, 63));
                wdata_p[i] = $urandom;
            end
            @(posedge clk); #1;
        end
        rst_p = 3'b000;
        req_p = 3'b000;
        repeat (12) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
